// File: rtl/vending_pkg.sv
// Shared types and constants for the multi-item vending machine:
// FSM states, error codes and the product price table.
package vending_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CREDIT = 2'd1,
        VEND   = 2'd2,
        CHANGE = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_FUNDS    = 2'b01;
    localparam logic [1:0] ERR_SOLD_OUT = 2'b10;
    localparam logic [1:0] ERR_COIN     = 2'b11;

    // Items beyond the four listed products fall back to the top price.
    function automatic logic [7:0] price_of(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'd15;
            4'd1:    return 8'd25;
            4'd2:    return 8'd50;
            default: return 8'd100;
        endcase
    endfunction

endpackage

// File: rtl/vend_stock_bank.sv
// Per-item stock counters: reload wins over decrement, counters saturate at
// zero, and an empty flag per item feeds the sold-out check.
module vend_stock_bank #(
    parameter int N_ITEMS    = 4,
    parameter int STOCK_W    = 4,
    parameter int INIT_STOCK = 8,
    localparam int SEL_W     = $clog2(N_ITEMS)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             reload,
    input  logic                             dec_en,
    input  logic [SEL_W-1:0]                 dec_idx,
    output logic [N_ITEMS-1:0]               empty
);

    logic [N_ITEMS-1:0][STOCK_W-1:0] stock;

    for (genvar g = 0; g < N_ITEMS; g++) begin : g_item
        logic [STOCK_W-1:0] cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                cnt <= STOCK_W'(INIT_STOCK);
            else if (reload)
                cnt <= STOCK_W'(INIT_STOCK);
            else if (dec_en && dec_idx == SEL_W'(g) && cnt != '0)
                cnt <= cnt - STOCK_W'(1);
        end

        assign stock[g] = cnt;
        assign empty[g] = (stock[g] == '0);
    end

endmodule

// File: rtl/vending_machine_multi.sv
// Multi-item vending machine: coin credit accumulation, priced selection
// with sold-out / funds checks, one-cycle vend pulse and change refund.
module vending_machine_multi
    import vending_pkg::*;
#(
    parameter int N_ITEMS    = 4,
    parameter int MONEY_W    = 6,
    parameter int CREDIT_W   = 8,
    parameter int STOCK_W    = 4,
    parameter int INIT_STOCK = 8,
    localparam int SEL_W     = $clog2(N_ITEMS)
) (
    input  logic                i_clk,
    input  logic                i_resetn,
    input  logic                i_coin_valid,
    input  logic [MONEY_W-1:0]  i_money_in,
    input  logic                i_select_valid,
    input  logic [SEL_W-1:0]    i_select,
    input  logic                i_cancel,
    input  logic                i_restock,
    output logic                o_dispense,
    output logic [SEL_W-1:0]    o_item,
    output logic                o_change,
    output logic [CREDIT_W-1:0] o_change_amt,
    output logic [CREDIT_W-1:0] o_credit,
    output logic                o_busy,
    output logic [1:0]          o_err
);

    state_t              state;
    logic [CREDIT_W-1:0] credit;
    logic [N_ITEMS-1:0]  empty;

    logic [CREDIT_W:0]   coin_sum;
    logic [31:0]         sel_price;
    logic                in_range;
    logic                sel_empty;
    logic                sel_funds;
    logic [CREDIT_W-1:0] vend_price;

    vend_stock_bank #(
        .N_ITEMS   (N_ITEMS),
        .STOCK_W   (STOCK_W),
        .INIT_STOCK(INIT_STOCK)
    ) u_stock (
        .clk    (i_clk),
        .rst_n  (i_resetn),
        .reload (i_restock),
        .dec_en (state == VEND),
        .dec_idx(o_item),
        .empty  (empty)
    );

    // Selection is judged against stored credit; a same-cycle coin never counts.
    always_comb begin
        coin_sum   = {1'b0, credit} + (CREDIT_W+1)'(i_money_in);
        sel_price  = 32'(price_of(4'(i_select)));
        in_range   = ({1'b0, i_select} < (SEL_W+1)'(N_ITEMS));
        sel_empty  = in_range ? empty[i_select] : 1'b1;
        sel_funds  = (32'(credit) >= sel_price);
        vend_price = CREDIT_W'(price_of(4'(o_item)));
    end

    assign o_credit = credit;

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state        <= IDLE;
            credit       <= '0;
            o_dispense   <= 1'b0;
            o_item       <= '0;
            o_change     <= 1'b0;
            o_change_amt <= '0;
            o_busy       <= 1'b0;
            o_err        <= ERR_NONE;
        end else begin
            o_dispense   <= 1'b0;
            o_change     <= 1'b0;
            o_change_amt <= '0;
            o_err        <= ERR_NONE;
            case (state)
                IDLE, CREDIT: begin
                    if (i_cancel) begin
                        if (i_coin_valid) o_err <= ERR_COIN;
                        if (credit != '0) begin
                            state        <= CHANGE;
                            o_change     <= 1'b1;
                            o_change_amt <= credit;
                            o_busy       <= 1'b1;
                        end
                    end else if (i_select_valid) begin
                        // A failed selection reports its own code over the ignored coin.
                        if (i_coin_valid) o_err <= ERR_COIN;
                        if (sel_empty)
                            o_err <= ERR_SOLD_OUT;
                        else if (!sel_funds)
                            o_err <= ERR_FUNDS;
                        else begin
                            state      <= VEND;
                            o_dispense <= 1'b1;
                            o_item     <= i_select;
                            o_busy     <= 1'b1;
                        end
                    end else if (i_coin_valid) begin
                        if (coin_sum[CREDIT_W])
                            o_err <= ERR_COIN;
                        else begin
                            credit <= coin_sum[CREDIT_W-1:0];
                            state  <= CREDIT;
                        end
                    end
                end
                VEND: begin
                    if (i_coin_valid) o_err <= ERR_COIN;
                    credit       <= credit - vend_price;
                    o_change     <= (credit != vend_price);
                    o_change_amt <= credit - vend_price;
                    state        <= CHANGE;
                end
                CHANGE: begin
                    if (i_coin_valid) o_err <= ERR_COIN;
                    credit <= '0;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vending_machine_multi.sv
// Directed bench: vend/change pulses go through an expected-event queue,
// credit / error / stock levels are checked inline after each step.
module tb_vending_machine_multi;

    logic       i_clk = 1'b0;
    logic       i_resetn = 1'b0;
    logic       i_coin_valid = 1'b0;
    logic [5:0] i_money_in = '0;
    logic       i_select_valid = 1'b0;
    logic [1:0] i_select = '0;
    logic       i_cancel = 1'b0;
    logic       i_restock = 1'b0;
    logic       o_dispense;
    logic [1:0] o_item;
    logic       o_change;
    logic [7:0] o_change_amt;
    logic [7:0] o_credit;
    logic       o_busy;
    logic [1:0] o_err;

    vending_machine_multi dut (
        .i_clk         (i_clk),
        .i_resetn      (i_resetn),
        .i_coin_valid  (i_coin_valid),
        .i_money_in    (i_money_in),
        .i_select_valid(i_select_valid),
        .i_select      (i_select),
        .i_cancel      (i_cancel),
        .i_restock     (i_restock),
        .o_dispense    (o_dispense),
        .o_item        (o_item),
        .o_change      (o_change),
        .o_change_amt  (o_change_amt),
        .o_credit      (o_credit),
        .o_busy        (o_busy),
        .o_err         (o_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic       is_change;
        logic [7:0] val;
    } ev_t;

    ev_t sb[$];
    int  n_pass = 0;
    int  n_fail = 0;
    int  n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_ev(input logic is_change, input logic [7:0] val);
        ev_t e;
        e.is_change = is_change;
        e.val       = val;
        sb.push_back(e);
    endtask

    // Drive one cycle of inputs from a falling edge; return at the next falling edge.
    task automatic step(input logic cv, input logic [5:0] m, input logic sv,
                        input logic [1:0] s, input logic cn, input logic rs);
        i_coin_valid   = cv;
        i_money_in     = m;
        i_select_valid = sv;
        i_select       = s;
        i_cancel       = cn;
        i_restock      = rs;
        @(posedge i_clk);
        #1;
        i_coin_valid   = 1'b0;
        i_select_valid = 1'b0;
        i_cancel       = 1'b0;
        i_restock      = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic coin(input logic [5:0] m);  step(1'b1, m, 1'b0, 2'd0, 1'b0, 1'b0); endtask
    task automatic sel(input logic [1:0] s);   step(1'b0, 6'd0, 1'b1, s, 1'b0, 1'b0); endtask
    task automatic cancel();                   step(1'b0, 6'd0, 1'b0, 2'd0, 1'b1, 1'b0); endtask
    task automatic idle();                     step(1'b0, 6'd0, 1'b0, 2'd0, 1'b0, 1'b0); endtask

    always @(negedge i_clk) begin
        if (i_resetn) begin
            if (o_dispense) begin
                if (sb.size() == 0) chk("sb_unexpected_dispense", 32'(o_dispense), 32'd0);
                else begin
                    ev_t e;
                    e = sb.pop_front();
                    chk("sb_dispense_kind", 32'(e.is_change), 32'd0);
                    chk("sb_item", 32'(o_item), 32'(e.val));
                end
            end
            if (o_change) begin
                if (sb.size() == 0) chk("sb_unexpected_change", 32'(o_change), 32'd0);
                else begin
                    ev_t e;
                    e = sb.pop_front();
                    chk("sb_change_kind", 32'(e.is_change), 32'd1);
                    chk("sb_change_amt", 32'(o_change_amt), 32'(e.val));
                end
            end
        end
    end

    initial begin
        repeat (2) @(negedge i_clk);
        chk("rst_credit", 32'(o_credit), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_dispense", 32'(o_dispense), 32'd0);
        chk("rst_change", 32'(o_change), 32'd0);
        chk("rst_item", 32'(o_item), 32'd0);
        chk("rst_change_amt", 32'(o_change_amt), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        i_resetn = 1'b1;
        idle();

        // 25+25, item 2 exact payment
        coin(6'd25);
        chk("t1_credit25", 32'(o_credit), 32'd25);
        coin(6'd25);
        chk("t1_credit50", 32'(o_credit), 32'd50);
        push_ev(1'b0, 8'd2);
        sel(2'd2);
        chk("t1_dispense", 32'(o_dispense), 32'd1);
        chk("t1_busy", 32'(o_busy), 32'd1);
        idle();
        chk("t1_no_change", 32'(o_change), 32'd0);
        chk("t1_stock2", 32'(dut.u_stock.stock[2]), 32'd7);
        idle();
        chk("t1_idle_busy", 32'(o_busy), 32'd0);
        chk("t1_credit0", 32'(o_credit), 32'd0);

        // insufficient funds, then refund
        coin(6'd10);
        sel(2'd1);
        chk("t2_err_funds", 32'(o_err), 32'd1);
        chk("t2_credit_kept", 32'(o_credit), 32'd10);
        push_ev(1'b1, 8'd10);
        cancel();
        chk("t2_change", 32'(o_change), 32'd1);
        idle();
        chk("t2_credit0", 32'(o_credit), 32'd0);

        // 63+50 for item 0, with a coin thrown in during VEND
        coin(6'd63);
        coin(6'd50);
        chk("t3_credit113", 32'(o_credit), 32'd113);
        push_ev(1'b0, 8'd0);
        push_ev(1'b1, 8'd98);
        sel(2'd0);
        step(1'b1, 6'd5, 1'b0, 2'd0, 1'b0, 1'b0);
        chk("t3_vend_coin_err", 32'(o_err), 32'd3);
        chk("t3_change_amt", 32'(o_change_amt), 32'd98);
        idle();
        chk("t3_credit0", 32'(o_credit), 32'd0);

        // coin and select together at credit 30
        coin(6'd25);
        coin(6'd5);
        push_ev(1'b0, 8'd1);
        push_ev(1'b1, 8'd5);
        step(1'b1, 6'd10, 1'b1, 2'd1, 1'b0, 1'b0);
        chk("t4_dispense", 32'(o_dispense), 32'd1);
        chk("t4_coin_err", 32'(o_err), 32'd3);
        idle();
        chk("t4_change", 32'(o_change), 32'd1);
        idle();

        // cancel with nothing inserted
        cancel();
        chk("t5_no_change", 32'(o_change), 32'd0);
        chk("t5_busy", 32'(o_busy), 32'd0);
        chk("t5_err", 32'(o_err), 32'd0);

        // credit overflow
        repeat (4) coin(6'd63);
        chk("t6_credit252", 32'(o_credit), 32'd252);
        coin(6'd63);
        chk("t6_ovf_err", 32'(o_err), 32'd3);
        chk("t6_ovf_credit", 32'(o_credit), 32'd252);
        push_ev(1'b1, 8'd252);
        cancel();
        idle();

        // sell out item 3, then restock
        for (int k = 0; k < 8; k++) begin
            coin(6'd50);
            coin(6'd50);
            push_ev(1'b0, 8'd3);
            sel(2'd3);
            idle();
            idle();
        end
        chk("t7_stock3_empty", 32'(dut.u_stock.stock[3]), 32'd0);
        coin(6'd50);
        coin(6'd50);
        sel(2'd3);
        chk("t7_sold_out", 32'(o_err), 32'd2);
        chk("t7_credit_kept", 32'(o_credit), 32'd100);
        step(1'b0, 6'd0, 1'b0, 2'd0, 1'b0, 1'b1);
        chk("t7_restocked", 32'(dut.u_stock.stock[3]), 32'd8);
        push_ev(1'b0, 8'd3);
        sel(2'd3);
        chk("t7_dispense", 32'(o_dispense), 32'd1);
        step(1'b0, 6'd0, 1'b0, 2'd0, 1'b0, 1'b1);
        chk("t7_reload_wins", 32'(dut.u_stock.stock[3]), 32'd8);
        idle();
        chk("t7_credit0", 32'(o_credit), 32'd0);

        // reset while vending
        coin(6'd25);
        i_select_valid = 1'b1;
        i_select       = 2'd0;
        @(posedge i_clk);
        #1;
        i_resetn       = 1'b0;
        i_select_valid = 1'b0;
        @(negedge i_clk);
        chk("t8_dispense", 32'(o_dispense), 32'd0);
        chk("t8_credit", 32'(o_credit), 32'd0);
        chk("t8_busy", 32'(o_busy), 32'd0);
        chk("t8_stock0", 32'(dut.u_stock.stock[0]), 32'd8);
        i_resetn = 1'b1;
        repeat (3) idle();
        chk("t8_change", 32'(o_change), 32'd0);
        chk("t8_idle_credit", 32'(o_credit), 32'd0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
